fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised pipeline front-end driver: generates a PC stream into a pipeline over the DIR/ack input handshake, and collects pipeline results over the DOR/ack output handshake into a show-ahead result FIFO. Issue is credit-limited, so results are never dropped. Supports PC redirect and configurable stride, and can be back-pressured by the consumer. Sits between the fetch/branch logic and the instruction pipeline, replacing hand-written bench-side handshake FSMs.

## Interface
- ADDR_W, 32, PC / pipeline input width
- DATA_W, 32, pipeline output / result width
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2
- PC_STEP, 1, PC increment per accepted issue
- RESET_PC, 0, PC value after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  allow new issues
- redirect_valid  in  1  load redirect_pc as next issue PC
- redirect_pc  in  ADDR_W  redirect target
- pipe_dir  out  1  data-in-ready to pipeline
- pipe_data_in  out  ADDR_W  PC presented to pipeline
- pipe_ack_in  in  1  pipeline accepted pipe_data_in
- pipe_dor  in  1  pipeline data-out-ready
- pipe_data_out  in  DATA_W  pipeline result
- pipe_ack_out  out  1  result captured
- res_valid  out  1  FIFO non-empty
- res_data  out  DATA_W  FIFO head
- res_pc  out  ADDR_W  PC tag of head (see Configuration)
- res_ready  in  1  consumer pops head
- outstanding  out  $clog2(FIFO_DEPTH)+1  issued, not yet captured
- err_spurious  out  1  sticky: DOR captured with outstanding==0

## Operation
- Reset: all outputs 0; PC=RESET_PC; issue FSM ISSUE_IDLE; capture FSM CAP_WAIT; FIFO empty; redirect pending cleared. Reset mid-handshake abandons it with no recovery.
- Credit: credit = (outstanding + fifo_count < FIFO_DEPTH).
- Issue FSM:
  - ISSUE_IDLE: if enable && credit: pipe_data_in<=PC, pipe_dir<=1 -> ISSUE_REQ.
  - ISSUE_REQ: pipe_dir is held, and pipe_data_in is held stable, until pipe_ack_in is sampled high; on ack: pipe_dir<=0, outstanding+1, PC<=pending redirect ? target : PC+PC_STEP -> ISSUE_RELEASE. Deasserting enable does not retract a request.
  - ISSUE_RELEASE: wait for pipe_ack_in low -> ISSUE_IDLE.
- Redirect: in IDLE/RELEASE, PC<=redirect_pc next cycle. In REQ, the target is latched as pending and applied at ack; the in-flight PC still completes. The last redirect wins.
- PC arithmetic is modulo 2^ADDR_W and wraps silently.
- Capture FSM:
  - CAP_WAIT: if pipe_dor && FIFO not full: push pipe_data_out, pipe_ack_out<=1, outstanding-1 (saturating at 0; set err_spurious if it was 0) -> CAP_ACKED.
  - CAP_ACKED: pipe_ack_out<=0 -> CAP_WAIT.
- Same-cycle issue-ack and capture: outstanding is unchanged.
- FIFO: show-ahead; pop on res_valid && res_ready; pop when empty is ignored. Simultaneous push/pop keeps count; the pointers wrap modulo FIFO_DEPTH.

## Timing
- pipe_dir rises 1 cycle after enable&&credit is sampled in IDLE.
- pipe_dir falls 1 cycle after pipe_ack_in is sampled high.
- Minimum issue period: 3 cycles with a 1-cycle ack pulse.
- pipe_ack_out is a 1-cycle pulse, 1 cycle after pipe_dor is sampled; minimum capture period 2 cycles.
- res_valid rises 1 cycle after the capturing edge.
- Full FIFO stalls capture: pipe_ack_out stays 0 and pipe_dor is left pending.

## Configuration
- FETCH_SEQ_TAG_EN defined: a FIFO_DEPTH×ADDR_W in-order tag FIFO records each acked PC. On capture, its head moves into the result FIFO alongside the data, and res_pc shows the head's PC.
- Not defined: no tag storage; res_pc tied to 0.

## Test plan
- Reset, enable=1, pipeline acks each DIR 1 cycle later -> pipe_data_in sequence 0,1,2,3; pipe_dir low in RELEASE; outstanding reaches 4, then issue stalls with res_ready=0 and no DOR.
- PC_STEP=4, RESET_PC=0xFFFFFFF8 -> issues 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- redirect_valid with 0x100 while in REQ at PC=2 -> 2 still completes; next issue is 0x100, then 0x101.
- DOR data 0xA5, 0x5A with res_ready=0 -> two 1-cycle pipe_ack_out pulses; res_data=0xA5; after pop, res_data=0x5A (res_pc=1 with TAG_EN).
- FIFO full (4 entries), pipe_dor held high -> no pipe_ack_out until one pop, then ack occurs 1 cycle later.
- pipe_dor asserted with outstanding=0 -> data captured, err_spurious=1 and stays set until reset.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC issue over DIR/ack, result capture over DOR/ack into a show-ahead FIFO
// Optional PC tagging of results when FETCH_SEQ_TAG_EN is defined (res_pc tied to 0 otherwise).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enable                          allow new issues
//   redirect_valid, redirect_pc     load redirect target as next issue PC
//   pipe_dir, pipe_data_in          request + PC toward pipeline
//   pipe_ack_in                     pipeline accepted the PC
//   pipe_dor, pipe_data_out         pipeline result available
//   pipe_ack_out                    1-cycle pulse: result captured
//   res_valid, res_data, res_pc     FIFO head (show-ahead)
//   res_ready                       consumer pops head
//   outstanding                     issued but not yet captured
//   err_spurious                    sticky: capture with nothing outstanding
module fetch_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] PC_STEP = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            redirect_valid,
   input  logic [ADDR_W-1:0]               redirect_pc,
   output logic                            pipe_dir,
   output logic [ADDR_W-1:0]               pipe_data_in,
   input  logic                            pipe_ack_in,
   input  logic                            pipe_dor,
   input  logic [DATA_W-1:0]               pipe_data_out,
   output logic                            pipe_ack_out,
   output logic                            res_valid,
   output logic [DATA_W-1:0]               res_data,
   output logic [ADDR_W-1:0]               res_pc,
   input  logic                            res_ready,
   output logic [$clog2(FIFO_DEPTH):0]     outstanding,
   output logic                            err_spurious
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {ISSUE_IDLE, ISSUE_REQ, ISSUE_RELEASE} issue_t;
   typedef enum logic {CAP_WAIT, CAP_ACKED} cap_t;
   issue_t is_q, is_d;
   cap_t cs_q, cs_d;
   logic [ADDR_W-1:0] pc_q, pc_d, din_q, din_d, pend_pc_q, pend_pc_d;
   logic pend_q, pend_d, err_q, err_d;
   logic [CW-1:0] out_q, out_d, cnt_q, cnt_d;
   logic [PW-1:0] wr_q, rd_q;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic credit, issue_ack, push, pop, full;

   assign full = cnt_q == CW'(FIFO_DEPTH);
   assign credit = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH);
   assign push = cs_q == CAP_WAIT && pipe_dor && !full;
   assign pop = res_valid && res_ready;
   assign pipe_dir = is_q == ISSUE_REQ;
   assign pipe_data_in = din_q;
   assign pipe_ack_out = cs_q == CAP_ACKED;
   assign res_valid = cnt_q != '0;
   assign res_data = res_valid ? mem[rd_q] : '0;
   assign outstanding = out_q;
   assign err_spurious = err_q;

   // A redirect arriving during REQ is parked and applied at ack; a redirect
   // on the ack cycle itself wins over an older parked one.
   always_comb begin
      is_d = is_q;
      pc_d = pc_q;
      din_d = din_q;
      pend_d = pend_q;
      pend_pc_d = pend_pc_q;
      issue_ack = 1'b0;
      case (is_q)
         ISSUE_IDLE: begin
            if (enable && credit) begin
               din_d = pc_q;
               is_d = ISSUE_REQ;
            end
            if (redirect_valid) pc_d = redirect_pc;
         end
         ISSUE_REQ: begin
            if (redirect_valid) begin
               pend_d = 1'b1;
               pend_pc_d = redirect_pc;
            end
            if (pipe_ack_in) begin
               issue_ack = 1'b1;
               pc_d = pend_d ? pend_pc_d : pc_q + PC_STEP;
               pend_d = 1'b0;
               is_d = ISSUE_RELEASE;
            end
         end
         ISSUE_RELEASE: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (!pipe_ack_in) is_d = ISSUE_IDLE;
         end
         default: is_d = ISSUE_IDLE;
      endcase
   end

   always_comb begin
      cs_d = push ? CAP_ACKED : CAP_WAIT;
      out_d = (issue_ack && !push) ? out_q + CW'(1) :
              (push && !issue_ack && out_q != '0) ? out_q - CW'(1) : out_q;
      err_d = err_q | (push && out_q == '0);
      cnt_d = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         is_q <= ISSUE_IDLE;
         cs_q <= CAP_WAIT;
         pc_q <= RESET_PC;
         din_q <= '0;
         pend_q <= 1'b0;
         pend_pc_q <= '0;
         out_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         is_q <= is_d;
         cs_q <= cs_d;
         pc_q <= pc_d;
         din_q <= din_d;
         pend_q <= pend_d;
         pend_pc_q <= pend_pc_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         if (push) wr_q <= wr_q + PW'(1);
         if (pop) rd_q <= rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= pipe_data_out;
   end

`ifdef FETCH_SEQ_TAG_EN
   logic [ADDR_W-1:0] tag_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
   logic [PW-1:0] tw_q, tr_q;

   // Tag head advances only on legitimate captures; a spurious capture copies a stale tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         tw_q <= '0;
         tr_q <= '0;
      end else begin
         if (issue_ack) tw_q <= tw_q + PW'(1);
         if (push && out_q != '0) tr_q <= tr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (issue_ack) tag_mem[tw_q] <= din_q;
      if (push) pc_mem[wr_q] <= tag_mem[tr_q];
   end

   assign res_pc = res_valid ? pc_mem[rd_q] : '0;
`else
   assign res_pc = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0, redirect_valid = 1'b0, pipe_ack_in = 1'b0, pipe_dor = 1'b0, res_ready = 1'b0;
   logic [31:0] redirect_pc = '0, pipe_data_out = '0;
   logic pipe_dir, pipe_ack_out, res_valid, err_spurious;
   logic [31:0] pipe_data_in, res_data, res_pc;
   logic [2:0] outstanding;
   logic en2 = 1'b0, ack2 = 1'b0;
   logic dir2, ack_out2, valid2, err2;
   logic [31:0] din2, data2, pc2;
   logic [2:0] out2;
   int total = 0, bad = 0;

   typedef struct {logic [31:0] d; logic [31:0] t; bit ct;} res_t;
   logic [31:0] exp_pc_q[$];
   logic [31:0] iss_q[$];
   res_t res_q[$];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .enable(enable), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pipe_dir(pipe_dir), .pipe_data_in(pipe_data_in),
      .pipe_ack_in(pipe_ack_in), .pipe_dor(pipe_dor), .pipe_data_out(pipe_data_out),
      .pipe_ack_out(pipe_ack_out), .res_valid(res_valid), .res_data(res_data),
      .res_pc(res_pc), .res_ready(res_ready), .outstanding(outstanding),
      .err_spurious(err_spurious));

   fetch_sequencer #(.PC_STEP(32'd4), .RESET_PC(32'hFFFF_FFF8)) u2 (
      .clk(clk), .reset(reset), .enable(en2), .redirect_valid(1'b0),
      .redirect_pc(32'd0), .pipe_dir(dir2), .pipe_data_in(din2),
      .pipe_ack_in(ack2), .pipe_dor(1'b0), .pipe_data_out(32'd0),
      .pipe_ack_out(ack_out2), .res_valid(valid2), .res_data(data2),
      .res_pc(pc2), .res_ready(1'b0), .outstanding(out2),
      .err_spurious(err2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      pipe_ack_in = 1'b0;
      pipe_dor = 1'b0;
      res_ready = 1'b0;
      en2 = 1'b0;
      ack2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_pc_q.delete();
      iss_q.delete();
      res_q.delete();
   endtask

   task automatic do_issue();
      int n = 0;
      logic [31:0] e;
      while (!pipe_dir && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("dir_timeout", pipe_dir, 1);
      if (pipe_dir) begin
         e = exp_pc_q.size() ? exp_pc_q.pop_front() : 32'hDEAD_BEEF;
         chk("issue_pc", pipe_data_in, e);
         iss_q.push_back(e);
         pipe_ack_in = 1'b1;
         @(negedge clk);
         chk("dir_release", pipe_dir, 0);
         pipe_ack_in = 1'b0;
      end
   endtask

   task automatic do_cap(input logic [31:0] d);
      int n = 0;
      res_t r;
      pipe_dor = 1'b1;
      pipe_data_out = d;
      @(negedge clk);
      while (!pipe_ack_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ack_out", pipe_ack_out, 1);
      pipe_dor = 1'b0;
      r.d = d;
      r.ct = iss_q.size() != 0;
      r.t = r.ct ? iss_q.pop_front() : '0;
      res_q.push_back(r);
      @(negedge clk);
      chk("ack_pulse", pipe_ack_out, 0);
   endtask

   task automatic do_pop();
      res_t r;
      chk("res_valid", res_valid, 1);
      if (res_q.size()) begin
         r = res_q.pop_front();
         chk("res_data", res_data, r.d);
`ifdef FETCH_SEQ_TAG_EN
         if (r.ct) chk("res_pc", res_pc, r.t);
`else
         chk("res_pc", res_pc, 0);
`endif
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      chk("rst_dir", pipe_dir, 0);
      chk("rst_din", pipe_data_in, 0);
      chk("rst_ack_out", pipe_ack_out, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_out", outstanding, 0);
      chk("rst_err", err_spurious, 0);
      chk("rst_res_data", res_data, 0);
      // basic issue stream up to credit limit
      enable = 1'b1;
      for (int i = 0; i < 4; i++) exp_pc_q.push_back(i);
      repeat (4) do_issue();
      chk("out_full", outstanding, 4);
      repeat (6) begin
         @(negedge clk);
         chk("credit_stall", pipe_dir, 0);
      end
      // redirect during REQ at PC=2
      do_reset();
      enable = 1'b1;
      exp_pc_q.push_back(0);
      exp_pc_q.push_back(1);
      repeat (2) do_issue();
      begin
         int n = 0;
         while (!pipe_dir && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      chk("redir_dir", pipe_dir, 1);
      chk("redir_pc2", pipe_data_in, 2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("redir_hold_dir", pipe_dir, 1);
      chk("redir_hold_pc", pipe_data_in, 2);
      iss_q.push_back(2);
      pipe_ack_in = 1'b1;
      @(negedge clk);
      pipe_ack_in = 1'b0;
      exp_pc_q.push_back(32'h100);
      do_issue();
      chk("out4", outstanding, 4);
      // captures with res_ready low
      do_cap(32'hA5);
      do_cap(32'h5A);
      chk("cnt_out", outstanding, 2);
      do_pop();
      chk("after_pop_data", res_data, 32'h5A);
`ifdef FETCH_SEQ_TAG_EN
      chk("after_pop_pc", res_pc, 1);
`endif
      exp_pc_q.push_back(32'h101);
      do_issue();
      enable = 1'b0;
      do_cap(32'h11);
      do_cap(32'h22);
      do_cap(32'h44);
      chk("full_out", outstanding, 0);
      chk("full_err", err_spurious, 0);
      // full FIFO stalls capture until a pop
      pipe_dor = 1'b1;
      pipe_data_out = 32'h33;
      repeat (4) begin
         @(negedge clk);
         chk("full_stall", pipe_ack_out, 0);
      end
      do_pop();
      chk("pop_no_ack_yet", pipe_ack_out, 0);
      @(negedge clk);
      chk("ack_after_pop", pipe_ack_out, 1);
      pipe_dor = 1'b0;
      res_q.push_back('{d: 32'h33, t: 32'h0, ct: 1'b0});
      chk("spur_err", err_spurious, 1);
      chk("spur_out", outstanding, 0);
      @(negedge clk);
      repeat (4) do_pop();
      chk("drained", res_valid, 0);
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      res_ready = 1'b0;
      chk("empty_pop_valid", res_valid, 0);
      chk("err_sticky", err_spurious, 1);
      // PC wrap on the second instance
      do_reset();
      chk("err_cleared", err_spurious, 0);
      en2 = 1'b1;
      foreach (exp_pc_q[i]) exp_pc_q.delete(i);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] e;
         int n = 0;
         e = 32'hFFFF_FFF8 + 32'(i) * 32'd4;
         while (!dir2 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("wrap_dir", dir2, 1);
         chk("wrap_pc", din2, e);
         ack2 = 1'b1;
         @(negedge clk);
         ack2 = 1'b0;
      end
      chk("wrap_out", out2, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
